// File: rtl/inst_encoder_loader.sv
// Instruction encoder/loader: packs decoded fields into 32-bit words
// and streams them into instruction memory at consecutive addresses.
module inst_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              f_musel,
    input  logic [5:0]        f_rd,
    input  logic [5:0]        f_rs,
    input  logic [3:0]        f_aluop,
    input  logic [5:0]        f_rt,
    input  logic [15:0]       f_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_imm,
    output logic              err_ovf,
    output logic [ADDR_W:0]   inst_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic              at_end;
    logic              fin;
    logic              accept;
    logic              at_last;
    logic              imm_ok;
    logic [8:0]        imm9;
    logic [31:0]       word;

    // fin marks that the final word is in flight; no more accepts after it
    assign in_ready = (state == RUN) && !at_end && !fin;
    assign accept   = in_valid && in_ready;
    assign at_last  = (wr_addr == LAST_ADDR);
    assign imm_ok   = (f_imm[15:9] == {7{f_imm[8]}});
    assign imm9     = f_musel ? f_imm[8:0] : 9'd0;
    assign word     = {f_musel, f_rd, f_rs, f_aluop, f_rt, imm9};
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave RUN on the edge that closes the last write cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (fin) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Write port, address/count tracking and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wr_addr    <= '0;
            at_end     <= 1'b0;
            fin        <= 1'b0;
            err_imm    <= 1'b0;
            err_ovf    <= 1'b0;
            inst_count <= '0;
        end else begin
            mem_we <= accept;
            if (state == IDLE && start) begin
                wr_addr    <= base_addr;
                at_end     <= 1'b0;
                fin        <= 1'b0;
                err_imm    <= 1'b0;
                err_ovf    <= 1'b0;
                inst_count <= '0;
            end else if (state == DONE) begin
                fin <= 1'b0;
            end else if (accept) begin
                mem_addr   <= wr_addr;
                mem_wdata  <= word;
                wr_addr    <= wr_addr + 1'b1;
                inst_count <= inst_count + 1'b1;
                if (f_musel && !imm_ok) begin
                    err_imm <= 1'b1;
                end
                if (at_last) begin
                    at_end <= 1'b1;
                end
                if (at_last && !in_last) begin
                    err_ovf <= 1'b1;
                end
                if (at_last || in_last) begin
                    fin <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: encoding, immediate range,
// streaming, address overflow and mid-load reset.
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start2;
    logic [7:0]  base_addr;
    logic [1:0]  base2;
    logic        in_valid;
    logic        in_last;
    logic        f_musel;
    logic [5:0]  f_rd;
    logic [5:0]  f_rs;
    logic [3:0]  f_aluop;
    logic [5:0]  f_rt;
    logic [15:0] f_imm;

    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err_imm;
    logic        err_ovf;
    logic [8:0]  inst_count;

    logic        o_ready;
    logic        o_we;
    logic [1:0]  o_addr;
    logic [31:0] o_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err_imm;
    logic        o_err_ovf;
    logic [2:0]  o_count;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .f_musel(f_musel), .f_rd(f_rd), .f_rs(f_rs), .f_aluop(f_aluop),
        .f_rt(f_rt), .f_imm(f_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err_imm(err_imm), .err_ovf(err_ovf), .inst_count(inst_count)
    );

    inst_encoder_loader #(.ADDR_W(2)) u_ovf (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base2),
        .in_valid(in_valid), .in_ready(o_ready), .in_last(in_last),
        .f_musel(f_musel), .f_rd(f_rd), .f_rs(f_rs), .f_aluop(f_aluop),
        .f_rt(f_rt), .f_imm(f_imm), .mem_we(o_we), .mem_addr(o_addr),
        .mem_wdata(o_wdata), .busy(o_busy), .done(o_done),
        .err_imm(o_err_imm), .err_ovf(o_err_ovf), .inst_count(o_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load(input logic [7:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic set_fields(input logic m, input logic [5:0] rd,
                              input logic [5:0] rs, input logic [3:0] op,
                              input logic [5:0] rt, input logic [15:0] imm,
                              input logic last);
        f_musel  = m;
        f_rd     = rd;
        f_rs     = rs;
        f_aluop  = op;
        f_rt     = rt;
        f_imm    = imm;
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({mem_we, busy, done, err_imm, err_ovf, in_ready} !== 6'b0)
            $display("FAIL reset_flags got %b exp 000000",
                     {mem_we, busy, done, err_imm, err_ovf, in_ready});
        else passed++;
        total++;
        if (mem_addr !== 8'h00) $display("FAIL reset_addr got %h exp 00", mem_addr);
        else passed++;
        total++;
        if (mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", mem_wdata);
        else passed++;
        total++;
        if (inst_count !== 9'd0) $display("FAIL reset_count got %0d exp 0", inst_count);
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        begin_load(8'h10);
        total++;
        if ({busy, in_ready} !== 2'b11) $display("FAIL run_ready got %b exp 11", {busy, in_ready});
        else passed++;
        set_fields(1'b1, 6'd3, 6'd5, 4'd2, 6'd0, 16'hFFFF, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if ({mem_we, done} !== 2'b10) $display("FAIL single_we got %b exp 10", {mem_we, done});
        else passed++;
        total++;
        if (mem_addr !== 8'h10) $display("FAIL single_addr got %h exp 10", mem_addr);
        else passed++;
        total++;
        if (mem_wdata !== 32'h862901FF) $display("FAIL single_word got %h exp 862901ff", mem_wdata);
        else passed++;
        tick();
        total++;
        if ({done, mem_we, busy} !== 3'b100) $display("FAIL single_done got %b exp 100", {done, mem_we, busy});
        else passed++;
        total++;
        if (inst_count !== 9'd1 || err_imm !== 1'b0)
            $display("FAIL single_count got %0d/%b exp 1/0", inst_count, err_imm);
        else passed++;
        tick();
        total++;
        if (done !== 1'b0) $display("FAIL single_done_width got %b exp 0", done);
        else passed++;
    endtask

    task automatic test_no_imm();
        begin_load(8'h40);
        set_fields(1'b0, 6'd1, 6'd2, 4'd4, 6'd7, 16'h1234, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if (mem_wdata !== 32'h02120E00) $display("FAIL noimm_word got %h exp 02120e00", mem_wdata);
        else passed++;
        total++;
        if (mem_addr !== 8'h40) $display("FAIL noimm_addr got %h exp 40", mem_addr);
        else passed++;
        tick();
        total++;
        if ({done, err_imm} !== 2'b10) $display("FAIL noimm_err got %b exp 10", {done, err_imm});
        else passed++;
        tick();
    endtask

    task automatic test_imm_range();
        begin_load(8'h00);
        set_fields(1'b1, 6'd0, 6'd0, 4'd0, 6'd0, 16'd300, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if (mem_wdata !== 32'h8000012C) $display("FAIL imm300_word got %h exp 8000012c", mem_wdata);
        else passed++;
        total++;
        if (err_imm !== 1'b1) $display("FAIL imm300_err got %b exp 1", err_imm);
        else passed++;
        tick();
        total++;
        if ({done, err_imm} !== 2'b11) $display("FAIL imm300_sticky got %b exp 11", {done, err_imm});
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        begin_load(8'h20);
        total++;
        if (err_imm !== 1'b0) $display("FAIL b2b_err_clear got %b exp 0", err_imm);
        else passed++;
        set_fields(1'b0, 6'd1, 6'd0, 4'd1, 6'd0, 16'h0000, 1'b0);
        tick();
        total++;
        if ({mem_we, mem_addr} !== {1'b1, 8'h20}) $display("FAIL b2b_w0 got %b/%h exp 1/20", mem_we, mem_addr);
        else passed++;
        total++;
        if (mem_wdata !== 32'h02008000) $display("FAIL b2b_w0_word got %h exp 02008000", mem_wdata);
        else passed++;
        set_fields(1'b1, 6'd0, 6'd0, 4'd0, 6'd0, 16'hFF00, 1'b0);
        start     = 1'b1;
        base_addr = 8'h70;
        tick();
        start = 1'b0;
        total++;
        if ({mem_we, mem_addr} !== {1'b1, 8'h21}) $display("FAIL b2b_w1 got %b/%h exp 1/21", mem_we, mem_addr);
        else passed++;
        total++;
        if ({mem_wdata, err_imm} !== {32'h80000100, 1'b0})
            $display("FAIL b2b_m256 got %h/%b exp 80000100/0", mem_wdata, err_imm);
        else passed++;
        set_fields(1'b1, 6'd0, 6'd0, 4'd0, 6'd0, 16'h0100, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if ({mem_we, mem_addr, done} !== {1'b1, 8'h22, 1'b0})
            $display("FAIL b2b_w2 got %b/%h/%b exp 1/22/0", mem_we, mem_addr, done);
        else passed++;
        total++;
        if ({mem_wdata, err_imm} !== {32'h80000100, 1'b1})
            $display("FAIL b2b_p256 got %h/%b exp 80000100/1", mem_wdata, err_imm);
        else passed++;
        tick();
        total++;
        if ({done, mem_we, inst_count} !== {2'b10, 9'd3})
            $display("FAIL b2b_done got %b/%b/%0d exp 1/0/3", done, mem_we, inst_count);
        else passed++;
        tick();
        total++;
        if ({done, busy} !== 2'b00) $display("FAIL b2b_idle got %b exp 00", {done, busy});
        else passed++;
    endtask

    task automatic test_overflow();
        start2 = 1'b1;
        base2  = 2'd2;
        tick();
        start2 = 1'b0;
        set_fields(1'b0, 6'd9, 6'd0, 4'd3, 6'd0, 16'h0000, 1'b0);
        tick();
        total++;
        if ({o_we, o_addr, o_ready} !== {1'b1, 2'd2, 1'b1})
            $display("FAIL ovf_w0 got %b/%0d/%b exp 1/2/1", o_we, o_addr, o_ready);
        else passed++;
        tick();
        total++;
        if ({o_we, o_addr, o_ready} !== {1'b1, 2'd3, 1'b0})
            $display("FAIL ovf_w1 got %b/%0d/%b exp 1/3/0", o_we, o_addr, o_ready);
        else passed++;
        tick();
        total++;
        if ({o_done, o_we, o_err_ovf} !== 3'b101)
            $display("FAIL ovf_done got %b exp 101", {o_done, o_we, o_err_ovf});
        else passed++;
        total++;
        if (o_count !== 3'd2) $display("FAIL ovf_count got %0d exp 2", o_count);
        else passed++;
        in_valid = 1'b0;
        tick();
        total++;
        if ({o_done, o_busy, o_we} !== 3'b000) $display("FAIL ovf_idle got %b exp 000", {o_done, o_busy, o_we});
        else passed++;
    endtask

    task automatic test_reset_midload();
        begin_load(8'h50);
        set_fields(1'b0, 6'd2, 6'd2, 4'd2, 6'd2, 16'h0000, 1'b0);
        tick();
        in_valid = 1'b0;
        total++;
        if (mem_we !== 1'b1) $display("FAIL rst_mid_we got %b exp 1", mem_we);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if ({mem_we, busy, done, inst_count} !== {3'b000, 9'd0})
            $display("FAIL rst_mid_clear got %b/%b/%b/%0d exp 0/0/0/0", mem_we, busy, done, inst_count);
        else passed++;
        total++;
        if ({mem_addr, mem_wdata} !== 40'h0) $display("FAIL rst_mid_port got %h/%h exp 0/0", mem_addr, mem_wdata);
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if ({done, mem_we, busy} !== 3'b000) $display("FAIL rst_mid_nodone got %b exp 000", {done, mem_we, busy});
        else passed++;
        begin_load(8'h60);
        set_fields(1'b1, 6'd63, 6'd0, 4'd15, 6'd0, 16'h00FF, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h60, 32'hFE0780FF})
            $display("FAIL rst_restart got %b/%h/%h exp 1/60/fe0780ff", mem_we, mem_addr, mem_wdata);
        else passed++;
        tick();
        total++;
        if ({done, inst_count, err_imm} !== {1'b1, 9'd1, 1'b0})
            $display("FAIL rst_restart_done got %b/%0d/%b exp 1/1/0", done, inst_count, err_imm);
        else passed++;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        base_addr = 8'h00;
        base2     = 2'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        f_musel   = 1'b0;
        f_rd      = '0;
        f_rs      = '0;
        f_aluop   = '0;
        f_rt      = '0;
        f_imm     = '0;
        test_reset();
        test_single();
        test_no_imm();
        test_imm_range();
        test_back_to_back();
        test_overflow();
        test_reset_midload();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the instruction decoder: packs per-field inputs (select, register indices, ALU op, immediate) into the 32-bit instruction word the decoder consumes.
- Writes each packed word into instruction memory at consecutive addresses, so a program can be streamed in from a host or test source.
- Sits between the program source (valid/ready stream) and the instruction memory write port.
- Flags immediates that do not fit the 9-bit signed field, and address-space overflow.

Parameters:
- ADDR_W, 8, instruction memory address width; the last usable address is 2^ADDR_W-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE.
- base_addr  input  ADDR_W  first write address; sampled on start.
- in_valid  input  1  field set valid.
- in_ready  output  1  encoder can accept a field set.
- in_last  input  1  marks the final instruction of the program.
- f_musel  input  1  immediate-select bit; becomes word bit [31].
- f_rd  input  6  destination register; becomes bits [30:25].
- f_rs  input  6  source register; becomes bits [24:19].
- f_aluop  input  4  ALU op; becomes bits [18:15]. The value 0 decodes as a no-write instruction and is encoded unchanged.
- f_rt  input  6  second source register; becomes bits [14:9].
- f_imm  input  16  signed immediate; low 9 bits become bits [8:0].
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  encoded instruction word.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a load ends.
- err_imm  output  1  sticky: an immediate was out of range during this load.
- err_ovf  output  1  sticky: address space was exhausted before in_last.
- inst_count  output  ADDR_W+1  number of words written in this load.

Behaviour:
- Reset values (next edge with rst=1): every output 0. State IDLE. Internal wr_addr=0, at_end=0. Reset mid-load aborts the load immediately: no further mem_we and no done pulse.
- States:
  - IDLE: start moves to RUN. On that transition wr_addr<=base_addr, and inst_count, err_imm, err_ovf and at_end clear.
  - RUN: in_ready = 1 while at_end=0. An accept is in_valid && in_ready.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Encoding: word = {f_musel, f_rd, f_rs, f_aluop, f_rt, imm9}.
  - If f_musel=1, imm9 = f_imm[8:0].
  - If f_musel=0, imm9 = 0 and no range check is done.
- Range check (f_musel=1 only): f_imm is in range iff f_imm[15:9] all equal f_imm[8], i.e. -256..255.
  - Out of range: the word is still written with the truncated f_imm[8:0], and err_imm is set (sticky until the next start).
- Latency: 1 cycle. An accept at edge N gives mem_we=1 during cycle N+1, with mem_addr = wr_addr at accept time and mem_wdata = the encoded word.
- mem_we deasserts the cycle after unless another accept occurred. Back-to-back accepts give one write per cycle.
- On each accept: wr_addr increments and inst_count increments.
  - If the accepted wr_addr == 2^ADDR_W-1, at_end<=1, so in_ready drops the next cycle. wr_addr wraps internally but is never used again.
- End of load, always after the final write strobe:
  - Accept with in_last=1 → RUN→DONE on the edge that ends the write cycle.
  - Accept at the last address with in_last=0 → same transition, and err_ovf=1.
  - Accept at the last address with in_last=1 → normal end, err_ovf=0.
- start during RUN or DONE is ignored. in_valid outside RUN is ignored (in_ready=0).
- busy=1 in RUN only. Error flags and inst_count hold until the next start.

Test Plan:
- start, base_addr=0x10; one accept with f_musel=1, f_rd=3, f_rs=5, f_aluop=2, f_rt=0, f_imm=0xFFFF (-1), in_last=1 → next cycle mem_we=1, mem_addr=0x10, mem_wdata=0x862901FF; done pulses the following cycle; inst_count=1, err_imm=0.
- f_musel=0, f_rd=1, f_rs=2, f_aluop=4, f_rt=7, f_imm=0x1234 → mem_wdata=0x02120E00, err_imm stays 0.
- f_musel=1, all register fields 0, f_aluop=0, f_imm=300 → mem_wdata=0x8000012C, err_imm=1 and still 1 at done.
- Three accepts on consecutive cycles from base 0x20, the third with in_last=1 → mem_we high for 3 consecutive cycles at addresses 0x20, 0x21, 0x22; inst_count=3; single done pulse.
- ADDR_W=2, base_addr=2, in_valid held high, in_last=0 → writes at 2 and 3 only; in_ready low after the second accept; done pulses with err_ovf=1 and inst_count=2.
- rst asserted the cycle after an accept → mem_we=0 from the next edge, no done pulse, all outputs 0, state IDLE; a new start works normally.
